// File: rtl/result_streamer_bram_pkg.sv
// result_streamer_bram shared constants.
// Sizes shared by the streamer, its FIFO and the bench.
package result_streamer_bram_pkg;

  localparam int CNT_BIT    = 31;
  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 32;
  localparam int MEM_DEPTH  = 4096;
  localparam int NUM_CORE   = 2;
  localparam int LANE_WIDTH = DATA_WIDTH / NUM_CORE;
  localparam int SUM_WIDTH  = 32;
  localparam int FIFO_DEPTH = 4;

  // Width of an occupancy counter able to hold 0..depth.
  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/result_streamer_bram_if.sv
// result_streamer_bram output stream bundle.
// valid/ready word stream with an end-of-run marker.
interface result_streamer_bram_if
  import result_streamer_bram_pkg::*;
#(
  parameter int DWIDTH = DATA_WIDTH
);

  logic              m_valid;
  logic              m_ready;
  logic [DWIDTH-1:0] m_data;
  logic              m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/result_streamer_bram_fifo.sv
// sync_fifo_fwft: small first-word fall-through FIFO.
// Head word is visible on dout_o whenever empty_o is low.
module sync_fifo_fwft
  import result_streamer_bram_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int W     = DATA_WIDTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= din_i;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/result_streamer_bram.sv
// result_streamer_bram: drains the result BRAM onto a stream.
// Credit-limited reads feed a FWFT FIFO; lane sums track output.
module result_streamer_bram
  import result_streamer_bram_pkg::*;
#(
  parameter int CNT_BIT    = result_streamer_bram_pkg::CNT_BIT,
  parameter int DWIDTH     = DATA_WIDTH,
  parameter int AWIDTH     = ADDR_WIDTH,
  parameter int MEM_SIZE   = MEM_DEPTH,
  parameter int LANE_W     = LANE_WIDTH,
  parameter int SUM_W      = SUM_WIDTH,
  parameter int FIFO_DEPTH = result_streamer_bram_pkg::FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_run,
  input  logic [CNT_BIT-1:0] i_num_cnt,
  output logic               o_idle,
  output logic               o_read,
  output logic               o_done,
  output logic [AWIDTH-1:0]  addr_b1,
  output logic               ce_b1,
  output logic               we_b1,
  input  logic [DWIDTH-1:0]  q_b1,
  output logic [DWIDTH-1:0]  d_b1,
  result_streamer_bram_if.master m,
  output logic [SUM_W-1:0]   o_sum_0,
  output logic [SUM_W-1:0]   o_sum_1
);

  localparam int CW = occ_w(FIFO_DEPTH);

  if (DWIDTH != 2 * LANE_W || MEM_SIZE > (1 << AWIDTH)
      || FIFO_DEPTH < 2) begin : g_bad_cfg
    $error("result_streamer_bram: bad parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic               idle_q;
  logic               read_q;
  logic               done_q;
  logic [CNT_BIT-1:0] num_q;
  logic [CNT_BIT-1:0] rd_cnt_q;
  logic [CNT_BIT-1:0] out_cnt_q;
  logic [CNT_BIT-1:0] out_cnt_d;
  logic               inflight_q;
  logic [SUM_W-1:0]   sum0_q;
  logic [SUM_W-1:0]   sum1_q;

  logic               start;
  logic               hs;
  logic               credit;
  logic               rd_en;
  logic [DWIDTH-1:0]  head;
  logic               f_full;
  logic               f_empty;
  logic [CW-1:0]      f_count;

  assign start  = idle_q & i_run;
  assign hs     = ~f_empty & m.m_ready;
  assign credit = ~f_full
                & ((f_count + CW'(inflight_q)) < CW'(FIFO_DEPTH));
  assign rd_en  = read_q & (rd_cnt_q < num_q) & credit;
  assign out_cnt_d = out_cnt_q + CNT_BIT'(hs);

  assign o_idle  = idle_q;
  assign o_read  = read_q;
  assign o_done  = done_q;
  assign ce_b1   = rd_en;
  assign addr_b1 = rd_cnt_q[AWIDTH-1:0];
  assign we_b1   = 1'b0;
  assign d_b1    = '0;
  assign o_sum_0 = sum0_q;
  assign o_sum_1 = sum1_q;

  assign m.m_valid = ~f_empty;
  assign m.m_data  = f_empty ? '0 : head;
  assign m.m_last  = ~f_empty
                   & (out_cnt_q == num_q - CNT_BIT'(1));

  sync_fifo_fwft #(
    .DEPTH (FIFO_DEPTH),
    .W     (DWIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (inflight_q),
    .din_i   (q_b1),
    .pop_i   (hs),
    .dout_o  (head),
    .full_o  (f_full),
    .empty_o (f_empty),
    .count_o (f_count)
  );

  // Run-control FSM with registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idle_q  <= 1'b1;
      read_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_run) begin
            state_q <= S_RUN;
            idle_q  <= 1'b0;
            read_q  <= 1'b1;
          end
        end
        S_RUN: begin
          if (out_cnt_d == num_q) begin
            state_q <= S_DONE;
            read_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          idle_q  <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          idle_q  <= 1'b1;
          read_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read/output counters, in-flight flag and lane sums.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_q      <= '0;
      rd_cnt_q   <= '0;
      out_cnt_q  <= '0;
      inflight_q <= 1'b0;
      sum0_q     <= '0;
      sum1_q     <= '0;
    end else begin
      inflight_q <= rd_en;
      if (start) begin
        num_q     <= i_num_cnt;
        rd_cnt_q  <= '0;
        out_cnt_q <= '0;
        sum0_q    <= '0;
        sum1_q    <= '0;
      end else begin
        if (rd_en) rd_cnt_q <= rd_cnt_q + CNT_BIT'(1);
        out_cnt_q <= out_cnt_d;
        if (hs) begin
          sum0_q <= sum0_q + SUM_W'(head[DWIDTH-1:LANE_W]);
          sum1_q <= sum1_q + SUM_W'(head[LANE_W-1:0]);
        end
      end
    end
  end

endmodule
